// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, IR presentation
// to the control unit, redirect inputs and status flags.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [3:0]  function_code;
  logic [15:0] pc;
  logic        Jump;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halted;
  logic        imem_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, function_code,
           pc, halted, imem_err,
    input  imem_ack, imem_rdata, instr_ready, Jump, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, function_code,
           pc, halted, imem_err,
    output imem_ack, imem_rdata, instr_ready, Jump, branch_taken, branch_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/HOLD/HALT sequencer holding pc and IR.
// Optional macro FETCH_TIMEOUT_EN adds a REQ-state timeout fault.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_VECTOR   = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.master   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        handshake;
  logic [15:0] pc_next_seq;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;
`endif

  assign handshake   = (state_q == ST_HOLD) && bus.instr_ready;
  assign pc_next_seq = bus.Jump         ? {pc_q[15:12], ir_q[11:0]} :
                       bus.branch_taken ? bus.branch_target :
                                          pc_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef FETCH_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = ST_HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
`endif
      end
      ST_HOLD: begin
        if (handshake) begin
          // A halt instruction freezes pc on itself; redirects are not applied.
          if (ir_q[15:12] == OP_HALT) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_next_seq;
            state_d = ST_REQ;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VECTOR;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Counter is held at zero outside REQ, so every REQ entry starts from zero.
  assign tmo_cnt_d = (state_q == ST_REQ) ? tmo_cnt_q + 16'd1 : 16'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.imem_err = err_q;
`else
  assign bus.imem_err = 1'b0;
`endif

  // All outputs decode registered state only; instr_ready never reaches imem_req.
  assign bus.imem_req      = (state_q == ST_REQ);
  assign bus.imem_addr     = pc_q;
  assign bus.instr_valid   = (state_q == ST_HOLD);
  assign bus.instr         = ir_q;
  assign bus.opcode        = ir_q[15:12];
  assign bus.function_code = ir_q[3:0];
  assign bus.pc            = pc_q;
  assign bus.halted        = (state_q == ST_HALT);

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, 16'h0000, word address loaded into pc on reset.
REQ-002 Parameter TIMEOUT_CYCLES, 16, REQ-state cycles without imem_ack before fault (used only with FETCH_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  16  word address of the fetch; equals pc.
REQ-007 imem_ack  input  1  memory response; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  16  fetched instruction word.
REQ-009 instr_valid  output  1  instr/opcode/function_code/pc presented to the control unit are valid.
REQ-010 instr_ready  input  1  downstream has consumed the instruction; redirect inputs valid this cycle.
REQ-011 instr  output  16  instruction register (IR).
REQ-012 opcode  output  4  IR[15:12], feeds control unit opcode.
REQ-013 function_code  output  4  IR[3:0], feeds control unit function_code.
REQ-014 pc  output  16  address of the instruction held in IR.
REQ-015 Jump  input  1  jump control from control unit, sampled only on handshake.
REQ-016 branch_taken  input  1  Branch AND-ed with ALU compare result (beq/bne), sampled only on handshake.
REQ-017 branch_target  input  16  branch destination from datapath.
REQ-018 halted  output  1  fetch stopped (halt opcode or fault).
REQ-019 imem_err  output  1  fetch timeout fault flag.

Function
REQ-020 FSM states IDLE, REQ, HOLD, HALT; registered outputs, no combinational path from instr_ready to imem_req.
REQ-021 IDLE: one cycle after reset release, then REQ; all outputs inactive.
REQ-022 REQ: imem_req=1, imem_addr=pc held stable until imem_ack=1 is sampled.
REQ-023 On imem_ack in REQ: IR<=imem_rdata, next state HOLD; ack on first REQ cycle accepted (zero-wait memory).
REQ-024 imem_ack outside REQ is ignored.
REQ-025 HOLD: instr_valid=1; IR, opcode, function_code, pc stable until instr_valid&&instr_ready.
REQ-026 Handshake next pc: Jump ? {pc[15:12],IR[11:0]} : branch_taken ? branch_target : pc+1; Jump has priority when both are set.
REQ-027 pc+1 wraps 16'hFFFF -> 16'h0000 with no flag.
REQ-028 After handshake the next state is REQ; instr_valid low for at least the one REQ cycle (minimum two cycles per instruction).
REQ-029 Handshake with opcode 4'b1111 (halt): pc unchanged, state HALT, halted=1, instr_valid=0, imem_req=0.
REQ-030 HALT is exited only by reset.
REQ-031 Jump/branch_taken/branch_target are ignored when instr_ready=0 or state!=HOLD.

Reset
REQ-032 Asserting rst_n=0 in any state, including mid-REQ, immediately forces state IDLE, pc=RESET_VECTOR, IR=16'h0000, imem_req=0, instr_valid=0, halted=0, imem_err=0, timeout counter=0.
REQ-033 A pending memory response is abandoned on reset; the first post-reset fetch is always RESET_VECTOR.

Configuration
REQ-034 Macro FETCH_TIMEOUT_EN defined: counter clears on REQ entry, increments each REQ cycle without ack; reaching TIMEOUT_CYCLES sets imem_err=1, halted=1, state HALT, imem_req=0.
REQ-035 Macro FETCH_TIMEOUT_EN undefined: REQ waits indefinitely, no counter logic, imem_err tied 0.

Verification
REQ-036 Reset, zero-wait memory returning 16'h3005 (addi) at 0, instr_ready=1 -> imem_addr 0x0000, then 0x0001; opcode 4'b0011, instr_valid one cycle per instruction.
REQ-037 At pc=0x0010, IR=16'h6ABC, Jump=1 and branch_taken=1, branch_target=0x0200 -> next imem_addr 0x0ABC.
REQ-038 IR=16'h4xxx (beq), branch_taken=1, target 0x0040 -> next fetch 0x0040; branch_taken=0 -> pc+1; pc=0xFFFF -> 0x0000.
REQ-039 instr_ready=0 for 5 cycles in HOLD -> instr_valid, instr, pc unchanged; ack pulses ignored; Jump toggling ignored.
REQ-040 Fetch 16'hF000 -> halted=1, imem_req stays 0 for 20 cycles; rst_n pulse mid-REQ with ack delayed -> refetch from RESET_VECTOR.
REQ-041 With FETCH_TIMEOUT_EN, imem_ack held 0 -> imem_err=1 and halted=1 after exactly 16 REQ cycles; without macro, imem_req stays 1.
